logs_nco_bank: RTL and testbench

- Multi-channel numerically-controlled oscillator bank; successor to the single-channel square NCO in the logs sound path.
- C channels share one phase adder, time-multiplexed: each `step` triggers a sweep that updates channels 0..C-1 on consecutive clocks.
- Per-channel frequency, duty and mode are held in a register file, written through a valid/ready config port.
- Outputs are one 1-bit tone per channel; these feed the downstream mixer.

---
 rtl/logs_nco_bank_if.sv | 39 +++
 rtl/logs_nco_bank.sv | 161 ++++++++++++++++
 tb/tb_logs_nco_bank.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logs_nco_bank_if.sv
// Step/config/tone bundle for logs_nco_bank. With LOGS_NCO_SYNC_EN defined
// the bundle also carries the hard-sync request.
interface logs_nco_bank_if #(
    parameter int N = 8,
    parameter int C = 4
);
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    logic          step;
    logic          busy;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_chan;
    logic [N-2:0]  cfg_freq;
    logic [N-1:0]  cfg_duty;
    logic          cfg_mode;
    logic [C-1:0]  snd;
`ifdef LOGS_NCO_SYNC_EN
    logic          sync;

    modport master (
        output step, sync, cfg_valid, cfg_chan, cfg_freq, cfg_duty, cfg_mode,
        input  busy, cfg_ready, snd
    );
    modport slave (
        input  step, sync, cfg_valid, cfg_chan, cfg_freq, cfg_duty, cfg_mode,
        output busy, cfg_ready, snd
    );
`else
    modport master (
        output step, cfg_valid, cfg_chan, cfg_freq, cfg_duty, cfg_mode,
        input  busy, cfg_ready, snd
    );
    modport slave (
        input  step, cfg_valid, cfg_chan, cfg_freq, cfg_duty, cfg_mode,
        output busy, cfg_ready, snd
    );
`endif
endinterface

// File: rtl/logs_nco_bank.sv
// Time-multiplexed bank of C square/pulse NCOs sharing one phase adder.
// Optional hard sync (phase realign to reset phases) under LOGS_NCO_SYNC_EN.
module logs_nco_bank #(
    parameter int          N    = 8,
    parameter int          C    = 4,
    parameter logic [31:0] SEED = 32'hD1BD_81EB
) (
    input  logic              clk,
    input  logic              reset_n,
    logs_nco_bank_if.slave    bus
);
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    // xorshift32 applied n times; used only to build reset-phase constants.
    function automatic logic [31:0] xorshift_iter(input logic [31:0] seed, input int n);
        logic [31:0] x;
        x = seed;
        for (int i = 0; i < n; i++) begin
            x = x ^ (x << 13);
            x = x ^ (x >> 17);
            x = x ^ (x << 5);
        end
        return x;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] slot_q, slot_d;
    logic          busy_q, busy_d;
    logic          cfg_accept;
    logic [C-1:0]  snd_vec;

    assign cfg_accept    = bus.cfg_valid & ~busy_q;
    assign bus.cfg_ready = ~busy_q;
    assign bus.busy      = busy_q;
    assign bus.snd       = snd_vec;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.step) begin
                    state_d = SWEEP;
                    slot_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            SWEEP: begin
                if (slot_q == CW'(C - 1)) begin
                    state_d = IDLE;
                    slot_d  = '0;
                    busy_d  = 1'b0;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                slot_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            busy_q  <= busy_d;
        end
    end

`ifdef LOGS_NCO_SYNC_EN
    // Latched at sweep start so the whole sweep realigns, not just slot 0.
    logic sync_q, sync_d;

    always_comb begin
        sync_d = sync_q;
        if (state_q == IDLE && bus.step) begin
            sync_d = bus.sync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
        end
    end
`endif

    for (genvar gi = 0; gi < C; gi++) begin : g_chan
        localparam logic [31:0] SEED_X     = xorshift_iter(SEED, gi);
        localparam logic [N-1:0] PHASE_INIT = SEED_X[N-1:0];

        logic [N-1:0] phase_q, phase_d;
        logic [N-2:0] freq_q, freq_d;
        logic [N-1:0] duty_q, duty_d;
        logic         mode_q, mode_d;
        logic         snd_q, snd_d;
        logic [N-1:0] p;
        logic         slot_hit;
        logic         cfg_hit;

        assign slot_hit = busy_q && (slot_q == CW'(gi));
        // Channel numbers at or above C match no slice, so such writes vanish.
        assign cfg_hit  = cfg_accept && (bus.cfg_chan == CW'(gi));

        always_comb begin
            p = phase_q;
`ifdef LOGS_NCO_SYNC_EN
            if (sync_q) begin
                p = PHASE_INIT;
            end
`endif
            phase_d = phase_q;
            freq_d  = freq_q;
            duty_d  = duty_q;
            mode_d  = mode_q;
            snd_d   = snd_q;
            if (slot_hit) begin
                snd_d   = mode_q ? (p < duty_q) : p[N-1];
                phase_d = p + {1'b0, freq_q};
            end
            if (cfg_hit) begin
                freq_d = bus.cfg_freq;
                duty_d = bus.cfg_duty;
                mode_d = bus.cfg_mode;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                phase_q <= PHASE_INIT;
                freq_q  <= '0;
                duty_q  <= N'(1) << (N - 1);
                mode_q  <= 1'b0;
                snd_q   <= 1'b0;
            end else begin
                phase_q <= phase_d;
                freq_q  <= freq_d;
                duty_q  <= duty_d;
                mode_q  <= mode_d;
                snd_q   <= snd_d;
            end
        end

        assign snd_vec[gi] = snd_q;
    end
endmodule

// File: tb/tb_logs_nco_bank.sv
// Directed bench for logs_nco_bank (N=8, C=4, plus a C=3 copy for the
// out-of-range channel write); a spec-level model tracks every channel.
module tb_logs_nco_bank;
    localparam int          N    = 8;
    localparam int          C    = 4;
    localparam logic [31:0] SEED = 32'hD1BD_81EB;

    logic clk;
    logic reset_n;

    logs_nco_bank_if #(.N(N), .C(C)) nco_if ();
    logs_nco_bank_if #(.N(N), .C(3)) nco3_if ();

    logs_nco_bank #(.N(N), .C(C), .SEED(SEED)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (nco_if)
    );

    logs_nco_bank #(.N(N), .C(3), .SEED(SEED)) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (nco3_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [N-1:0] m_phase [C];
    logic [N-2:0] m_freq  [C];
    logic [N-1:0] m_duty  [C];
    logic         m_mode  [C];
    logic [C-1:0] m_snd;

    typedef struct {
        int chan;
        int freq;
        int duty;
        int mode;
        int nsteps;
        int exp_high;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] seed_phase(input int c);
        logic [31:0] x;
        x = SEED;
        for (int i = 0; i < c; i++) begin
            x = x ^ (x << 13);
            x = x ^ (x >> 17);
            x = x ^ (x << 5);
        end
        return x[N-1:0];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < C; c++) begin
            m_phase[c] = seed_phase(c);
            m_freq[c]  = '0;
            m_duty[c]  = 8'h80;
            m_mode[c]  = 1'b0;
        end
        m_snd = '0;
    endtask

    task automatic model_sweep();
        logic [N-1:0] p;
        for (int c = 0; c < C; c++) begin
            p          = m_phase[c];
            m_snd[c]   = m_mode[c] ? (p < m_duty[c]) : p[N-1];
            m_phase[c] = p + {1'b0, m_freq[c]};
        end
    endtask

    task automatic do_step(input string tag);
        int bc;
        @(negedge clk);
        nco_if.step = 1'b1;
        @(negedge clk);
        nco_if.step = 1'b0;
        bc = 0;
        while (nco_if.busy && bc < 20) begin
            bc++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, bc, C);
        model_sweep();
        check({tag, " snd"}, nco_if.snd, m_snd);
    endtask

    task automatic cfg_write(input int chan, input int f, input int d, input int m);
        int w;
        w = 0;
        @(negedge clk);
        nco_if.cfg_valid = 1'b1;
        nco_if.cfg_chan  = 2'(chan);
        nco_if.cfg_freq  = 7'(f);
        nco_if.cfg_duty  = 8'(d);
        nco_if.cfg_mode  = 1'(m);
        while (!nco_if.cfg_ready && w < 20) begin
            w++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        nco_if.cfg_valid = 1'b0;
        if (chan < C) begin
            m_freq[chan] = 7'(f);
            m_duty[chan] = 8'(d);
            m_mode[chan] = 1'(m);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int highs;
        logic [2:0] exp3;

        vecs[0] = '{chan: 1, freq: 1,   duty: 128, mode: 0, nsteps: 512, exp_high: 256};
        vecs[1] = '{chan: 2, freq: 16,  duty: 64,  mode: 1, nsteps: 16,  exp_high: 4};
        vecs[2] = '{chan: 2, freq: 16,  duty: 64,  mode: 1, nsteps: 64,  exp_high: 16};
        vecs[3] = '{chan: 3, freq: 37,  duty: 0,   mode: 1, nsteps: 20,  exp_high: 0};
        vecs[4] = '{chan: 0, freq: 1,   duty: 255, mode: 1, nsteps: 256, exp_high: 255};
        vecs[5] = '{chan: 0, freq: 64,  duty: 0,   mode: 0, nsteps: 8,   exp_high: 4};
        vecs[6] = '{chan: 3, freq: 64,  duty: 0,   mode: 0, nsteps: 8,   exp_high: 4};
        vecs[7] = '{chan: 1, freq: 127, duty: 128, mode: 1, nsteps: 256, exp_high: 128};
        vecs[5].freq = 0;
        vecs[5] = '{chan: 0, freq: 64, duty: 0, mode: 0, nsteps: 8, exp_high: 4};

        reset_n           = 1'b0;
        nco_if.step       = 1'b0;
        nco_if.cfg_valid  = 1'b0;
        nco_if.cfg_chan   = '0;
        nco_if.cfg_freq   = '0;
        nco_if.cfg_duty   = '0;
        nco_if.cfg_mode   = 1'b0;
        nco3_if.step      = 1'b0;
        nco3_if.cfg_valid = 1'b0;
        nco3_if.cfg_chan  = '0;
        nco3_if.cfg_freq  = '0;
        nco3_if.cfg_duty  = '0;
        nco3_if.cfg_mode  = 1'b0;
`ifdef LOGS_NCO_SYNC_EN
        nco_if.sync       = 1'b0;
        nco3_if.sync      = 1'b0;
`endif
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", nco_if.busy, 1'b0);
        check("reset cfg_ready", nco_if.cfg_ready, 1'b1);
        check("reset snd", nco_if.snd, 4'b0000);
        check("reset snd c3", nco3_if.snd, 3'b000);
        reset_n = 1'b1;
        $display("reset released: busy=%0b ready=%0b snd=%b", nco_if.busy, nco_if.cfg_ready, nco_if.snd);

        // First sweeps with freq=0: phases hold, snd follows seed MSBs
        do_step("first_step");
        check("first_step snd0 seed bit7", nco_if.snd[0], 1'b1);
        do_step("second_step");
        $display("freq=0 sweeps: snd=%b", nco_if.snd);

        // Out-of-range channel on the C=3 copy: accepted, then discarded
        @(negedge clk);
        nco3_if.cfg_valid = 1'b1;
        nco3_if.cfg_chan  = 2'd3;
        nco3_if.cfg_freq  = 7'd100;
        nco3_if.cfg_duty  = 8'd0;
        nco3_if.cfg_mode  = 1'b1;
        check("oor cfg_ready", nco3_if.cfg_ready, 1'b1);
        @(posedge clk);
        #1;
        nco3_if.cfg_valid = 1'b0;
        for (int c = 0; c < 3; c++) exp3[c] = seed_phase(c) >> (N - 1);
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            nco3_if.step = 1'b1;
            @(negedge clk);
            nco3_if.step = 1'b0;
            bc = 0;
            while (nco3_if.busy && bc < 20) begin
                bc++;
                @(negedge clk);
            end
            check("oor busy_cycles", bc, 3);
            check("oor snd", nco3_if.snd, exp3);
        end
        $display("out-of-range write on C=3 bank: snd=%b", nco3_if.snd);

        // Table-driven waveform vectors
        for (int v = 0; v < 8; v++) begin
            cfg_write(vecs[v].chan, vecs[v].freq, vecs[v].duty, vecs[v].mode);
            highs = 0;
            for (int s = 0; s < vecs[v].nsteps; s++) begin
                do_step($sformatf("vec%0d step%0d", v, s));
                highs += int'(nco_if.snd[vecs[v].chan]);
            end
            check($sformatf("vec%0d high_count", v), highs, vecs[v].exp_high);
            $display("vector %0d: chan=%0d freq=%0d duty=%0d mode=%0d steps=%0d highs=%0d",
                     v, vecs[v].chan, vecs[v].freq, vecs[v].duty, vecs[v].mode,
                     vecs[v].nsteps, highs);
        end

        // Step held high: busy pattern 11110, three whole sweeps
        @(negedge clk);
        nco_if.step = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("held busy[%0d]", i), nco_if.busy, (i % 5) != 4);
            if (i == 13) nco_if.step = 1'b0;
        end
        repeat (3) model_sweep();
        check("held snd", nco_if.snd, m_snd);
        $display("held step: 3 sweeps, snd=%b", nco_if.snd);

        // Config write stalled by a sweep, accepted on first IDLE edge
        cfg_write(2, 0, 0, 1);
        @(negedge clk);
        nco_if.step = 1'b1;
        @(negedge clk);
        nco_if.step      = 1'b0;
        nco_if.cfg_valid = 1'b1;
        nco_if.cfg_chan  = 2'd2;
        nco_if.cfg_freq  = 7'd0;
        nco_if.cfg_duty  = 8'd255;
        nco_if.cfg_mode  = 1'b1;
        check("stall cfg_ready", nco_if.cfg_ready, 1'b0);
        bc = 0;
        while (!nco_if.cfg_ready && bc < 20) begin
            bc++;
            @(negedge clk);
        end
        check("stall wait_cycles", bc, 4);
        @(posedge clk);
        #1;
        nco_if.cfg_valid = 1'b0;
        model_sweep();
        check("stall sweep snd", nco_if.snd, m_snd);
        m_freq[2] = 7'd0;
        m_duty[2] = 8'd255;
        m_mode[2] = 1'b1;
        do_step("after_stall");
        $display("stalled write: waited=%0d snd=%b", bc, nco_if.snd);

        // Asynchronous reset in the middle of a sweep
        @(negedge clk);
        nco_if.step = 1'b1;
        @(negedge clk);
        nco_if.step = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset busy", nco_if.busy, 1'b0);
        check("midreset snd", nco_if.snd, 4'b0000);
        check("midreset cfg_ready", nco_if.cfg_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        do_step("post_reset");
        $display("mid-sweep reset: post-reset sweep snd=%b", nco_if.snd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
